// File: rtl/matrix_scalar_division_if.sv
// Element stream for the matrix-by-scalar divider: upstream element/scalar in,
// downstream quotient out with last-element and divide-by-zero markers.
interface matrix_scalar_division_if #(
    parameter int unsigned DW = 32
) ();
    logic          valid_in;
    logic          ready_in;
    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;
    logic          valid_out;
    logic          ready_out;
    logic [DW-1:0] result;
    logic          last_out;
    logic          div_by_zero;

    modport master (
        output valid_in, data_a, data_b, ready_out,
        input  ready_in, valid_out, result, last_out, div_by_zero
    );

    modport slave (
        input  valid_in, data_a, data_b, ready_out,
        output ready_in, valid_out, result, last_out, div_by_zero
    );
endinterface

// File: rtl/matrix_scalar_division.sv
// Streaming element-wise C = A / s using a bit-serial restoring divider on magnitudes;
// the scalar is captured on the first element of each ROWS*COLS frame.
module matrix_scalar_division #(
    parameter int unsigned DW   = 32,
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    matrix_scalar_division_if.slave bus
);

    localparam int unsigned NElem = ROWS * COLS;
    localparam int unsigned CntW  = (NElem > 1) ? $clog2(NElem) : 1;
    localparam int unsigned ItW   = $clog2(DW + 1);
    localparam logic [DW-1:0] MaxPos = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MinNeg = {1'b1, {(DW-1){1'b0}}};
    localparam logic [CntW-1:0] LastIdx = CntW'(NElem - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] elem_cnt_q;
    logic [ItW-1:0]  iter_q;
    logic [DW-1:0]   dvd_q;
    logic [DW-1:0]   rem_q;
    logic [DW-1:0]   scalar_q;
    logic            sign_a_q;
    logic [DW-1:0]   result_q;
    logic            dbz_q;

    logic            accept;
    logic [DW-1:0]   abs_a;
    logic [DW-1:0]   abs_s;
    logic [DW:0]     rem_sh;
    logic [DW+1:0]   trial;
    logic            q_bit;
    logic [DW-1:0]   rem_nxt;
    logic            neg_q;
    logic [DW-1:0]   res_fin;
    logic            unused_bits;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StCalc;
            StCalc:  if (iter_q == '0) state_d = StDone;
            StDone:  if (bus.ready_out) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs; ready_in is forced low while reset is held
    always_comb begin
        bus.ready_in    = (state_q == StIdle) && rst_n;
        bus.valid_out   = (state_q == StDone);
        bus.last_out    = (state_q == StDone) && (elem_cnt_q == LastIdx);
        bus.result      = result_q;
        bus.div_by_zero = dbz_q;
    end

    assign accept = bus.valid_in && bus.ready_in;

    // Magnitudes are unsigned, so |-2^(DW-1)| = 2^(DW-1) still fits in DW bits.
    assign abs_a = bus.data_a[DW-1] ? -bus.data_a : bus.data_a;
    assign abs_s = scalar_q[DW-1]   ? -scalar_q   : scalar_q;

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
    always_comb begin
        rem_sh  = {rem_q, dvd_q[DW-1]};
        trial   = {1'b0, rem_sh} - {2'b00, abs_s};
        q_bit   = ~trial[DW+1];
        rem_nxt = q_bit ? trial[DW-1:0] : rem_sh[DW-1:0];
    end

    // Top bits only matter when the divisor is zero, and that quotient is overridden.
    assign unused_bits = ^{trial[DW], rem_sh[DW]};

    // Sign fix-up and saturation of the unsigned quotient held in dvd_q.
    always_comb begin
        neg_q = sign_a_q ^ scalar_q[DW-1];
        if (scalar_q == '0) begin
            res_fin = sign_a_q ? MinNeg : MaxPos;
        end else if (neg_q) begin
            res_fin = -dvd_q;
        end else if (dvd_q[DW-1]) begin
            res_fin = MaxPos;
        end else begin
            res_fin = dvd_q;
        end
    end

    // Datapath and frame bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_cnt_q <= '0;
            iter_q     <= '0;
            dvd_q      <= '0;
            rem_q      <= '0;
            scalar_q   <= '0;
            sign_a_q   <= 1'b0;
            result_q   <= '0;
            dbz_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        dvd_q    <= abs_a;
                        sign_a_q <= bus.data_a[DW-1];
                        rem_q    <= '0;
                        iter_q   <= ItW'(DW);
                        if (elem_cnt_q == '0) scalar_q <= bus.data_b;
                    end
                end
                StCalc: begin
                    if (iter_q != '0) begin
                        rem_q  <= rem_nxt;
                        dvd_q  <= {dvd_q[DW-2:0], q_bit};
                        iter_q <= iter_q - 1'b1;
                    end else begin
                        result_q <= res_fin;
                        dbz_q    <= (scalar_q == '0);
                    end
                end
                StDone: begin
                    if (bus.ready_out) begin
                        elem_cnt_q <= (elem_cnt_q == LastIdx) ? '0 : elem_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_scalar_division.sv
// Randomized self-checking bench for matrix_scalar_division against a plain-arithmetic
// model of signed truncating division with frame-scalar capture.
module tb_matrix_scalar_division;

    localparam int unsigned DW    = 32;
    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 4;
    localparam int unsigned NElem = ROWS * COLS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    matrix_scalar_division_if #(.DW(DW)) bus ();

    matrix_scalar_division #(
        .DW   (DW),
        .ROWS (ROWS),
        .COLS (COLS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: element index within the frame, frame scalar, pending dividend
    int          m_idx = 0;
    logic [31:0] m_s   = '0;
    logic [31:0] m_a   = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (elem %0d, t=%0t)", tag, got, exp, m_idx, $time);
        end
    endtask

    function automatic logic [31:0] ref_quot(input logic [31:0] a, input logic [31:0] s);
        longint sa;
        longint ss;
        longint q;
        sa = longint'($signed(a));
        ss = longint'($signed(s));
        if (ss == 0) return (sa >= 0) ? 32'h7fff_ffff : 32'h8000_0000;
        q = sa / ss;
        if (q > 64'sd2147483647) q = 64'sd2147483647;
        return q[31:0];
    endfunction

    function automatic logic [31:0] rnd_val();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0:       v = 32'h8000_0000;
            1:       v = 32'h7fff_ffff;
            2:       v = $urandom;
            default: v = 32'($urandom_range(0, 4000)) - 32'd2000;
        endcase
        return v;
    endfunction

    // Called at a negedge; returns just after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int g;
        g = 0;
        bus.valid_in = 1'b1;
        bus.data_a   = a;
        bus.data_b   = b;
        while (!bus.ready_in && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) check_eq("accept_timeout", 64'(g), 64'd0);
        if (m_idx == 0) m_s = b;
        m_a = a;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        bus.data_a   = $urandom;
        bus.data_b   = $urandom;
    endtask

    // Waits for the result, optionally stalls it for hold cycles, then takes it.
    task automatic recv(input int hold);
        int          cnt;
        logic [31:0] exp_r;
        exp_r = ref_quot(m_a, m_s);
        cnt   = 0;
        do begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end while (!bus.valid_out && cnt < 200);
        check_eq("latency", 64'(cnt), 64'(DW + 1));
        check_eq("result", 64'(bus.result), 64'(exp_r));
        check_eq("last_out", 64'(bus.last_out), 64'(m_idx == NElem - 1));
        check_eq("div_by_zero", 64'(bus.div_by_zero), 64'(m_s == 32'd0));
        for (int h = 0; h < hold; h++) begin
            bus.valid_in = 1'b1;
            bus.data_a   = $urandom;
            @(posedge clk);
            @(negedge clk);
            check_eq("hold_result", 64'(bus.result), 64'(exp_r));
            check_eq("hold_valid_out", 64'(bus.valid_out), 64'd1);
            check_eq("hold_ready_in", 64'(bus.ready_in), 64'd0);
        end
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ready_out = 1'b0;
        check_eq("post_valid_out", 64'(bus.valid_out), 64'd0);
        check_eq("post_ready_in", 64'(bus.ready_in), 64'd1);
        m_idx = (m_idx + 1) % NElem;
    endtask

    task automatic do_elem(input logic [31:0] a, input logic [31:0] b, input int hold);
        send(a, b);
        recv(hold);
    endtask

    initial begin
        logic [31:0] pat [4];
        logic [31:0] s;

        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b0;
        bus.data_a    = '0;
        bus.data_b    = '0;
        pat[0] = 32'd100;
        pat[1] = -32'd100;
        pat[2] = 32'd7;
        pat[3] = -32'd7;

        repeat (3) @(negedge clk);
        check_eq("rst_ready_in", 64'(bus.ready_in), 64'd0);
        check_eq("rst_valid_out", 64'(bus.valid_out), 64'd0);
        check_eq("rst_result", 64'(bus.result), 64'd0);
        check_eq("rst_last_out", 64'(bus.last_out), 64'd0);
        check_eq("rst_div_by_zero", 64'(bus.div_by_zero), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Frame 1: s = 7, known pattern then random dividends, random ignored scalars
        for (int i = 0; i < NElem; i++)
            do_elem((i < 8) ? pat[i % 4] : rnd_val(), (i == 0) ? 32'd7 : $urandom, 0);

        // Frame 2: s = -3, mid-frame scalar change ignored, back-pressure on element 2
        do_elem(32'd10, -32'd3, 0);
        do_elem(-32'd10, 32'd5, 0);
        do_elem(rnd_val(), $urandom, 10);
        for (int i = 3; i < NElem; i++) do_elem(rnd_val(), $urandom, (i == 7) ? 3 : 0);

        // Frame 3: divide by zero
        do_elem(32'd5, 32'd0, 0);
        do_elem(-32'd5, 32'd1, 0);
        do_elem(32'd0, 32'd2, 0);
        for (int i = 3; i < NElem; i++) do_elem(rnd_val(), $urandom, 0);

        // Frame 4: s = -1, overflow case
        do_elem(32'h8000_0000, 32'hffff_ffff, 0);
        do_elem(32'h7fff_ffff, 32'd0, 0);
        for (int i = 2; i < NElem; i++) do_elem(rnd_val(), $urandom, 0);

        // Frame 5: s = 1, then reset in the middle of element 5
        do_elem(32'h8000_0000, 32'd1, 0);
        for (int i = 1; i < 5; i++) do_elem(rnd_val(), $urandom, 0);
        send(rnd_val(), $urandom);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid_out", 64'(bus.valid_out), 64'd0);
        check_eq("midrst_ready_in", 64'(bus.ready_in), 64'd0);
        check_eq("midrst_result", 64'(bus.result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_idx = 0;
        @(negedge clk);

        // Frame 6: small random signed scalar, counter must restart at 0
        s = 32'($urandom_range(2, 50));
        if ($urandom_range(0, 1) == 1) s = -s;
        for (int i = 0; i < NElem; i++) do_elem(rnd_val(), (i == 0) ? s : $urandom, 0);

        // Frame 7: fully random scalar and dividends
        for (int i = 0; i < NElem; i++) do_elem($urandom, $urandom, (i == 4) ? 2 : 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
